// File: rtl/tcp_pkg.sv
// rtl/tcp_pkg.sv - shared state codes, flag indices and sequence type for the TCP server core
package tcp_pkg;

    typedef logic [31:0] seq_t;

    typedef enum logic [2:0] {
        ST_CLOSED      = 3'd0,
        ST_LISTEN      = 3'd1,
        ST_SYN_RCVD    = 3'd2,
        ST_ESTABLISHED = 3'd3,
        ST_CLOSE_WAIT  = 3'd4,
        ST_LAST_ACK    = 3'd5
    } tcp_state_e;

    localparam int FLAG_FIN = 0;
    localparam int FLAG_SYN = 1;
    localparam int FLAG_RST = 2;
    localparam int FLAG_PSH = 3;
    localparam int FLAG_ACK = 4;
    localparam int FLAG_URG = 5;

    localparam logic [5:0] F_FIN = 6'(1 << FLAG_FIN);
    localparam logic [5:0] F_SYN = 6'(1 << FLAG_SYN);
    localparam logic [5:0] F_RST = 6'(1 << FLAG_RST);
    localparam logic [5:0] F_ACK = 6'(1 << FLAG_ACK);

endpackage

// File: rtl/tcp_tx_slot.sv
// rtl/tcp_tx_slot.sv - single-entry TX header holding register with valid/ready handshake
// Ports: clk, rst (sync, active-high); load_i/flags_i/seq_i/ack_i capture a header;
//        tx_ready_i accepts it; tx_valid_o/tx_flags_o/tx_seq_o/tx_ack_o present it.
module tcp_tx_slot
    import tcp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [5:0] flags_i,
    input  seq_t       seq_i,
    input  seq_t       ack_i,
    input  logic       tx_ready_i,
    output logic       tx_valid_o,
    output logic [5:0] tx_flags_o,
    output seq_t       tx_seq_o,
    output seq_t       tx_ack_o
);

    logic       valid_q;
    logic [5:0] flags_q;
    seq_t       seq_q;
    seq_t       ack_q;

    // The top only loads while the slot is empty, so fields stay frozen
    // from load until the handshake completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            flags_q <= '0;
            seq_q   <= '0;
            ack_q   <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            flags_q <= flags_i;
            seq_q   <= seq_i;
            ack_q   <= ack_i;
        end else if (valid_q && tx_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign tx_valid_o = valid_q;
    assign tx_flags_o = flags_q;
    assign tx_seq_o   = seq_q;
    assign tx_ack_o   = ack_q;

endmodule

// File: rtl/tcp_server_core.sv
// rtl/tcp_server_core.sv - passive-open TCP server connection controller (header level)
// Ports: clk, rst (sync, active-high); listen_en, app_close levels; RX header
//        rx_valid/rx_ready/rx_flags/rx_seq/rx_ack/rx_len; TX header
//        tx_valid/tx_ready/tx_flags/tx_seq/tx_ack; state code and conn_open.
// Optional macro TCP_SERVER_TIMEOUT_EN adds an idle timeout in SYN_RCVD/LAST_ACK.
module tcp_server_core
    import tcp_pkg::*;
#(
    parameter logic [31:0] ISN            = 32'h1000_0000,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        listen_en,
    input  logic        app_close,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [5:0]  rx_flags,
    input  logic [31:0] rx_seq,
    input  logic [31:0] rx_ack,
    input  logic [15:0] rx_len,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [5:0]  tx_flags,
    output logic [31:0] tx_seq,
    output logic [31:0] tx_ack,
    output logic [2:0]  state,
    output logic        conn_open
);

    tcp_state_e state_q, state_d;
    seq_t       snd_nxt_q, snd_nxt_d;
    seq_t       rcv_nxt_q, rcv_nxt_d;
    logic       tx_load;
    logic [5:0] tx_flags_d;
    seq_t       tx_seq_d, tx_ack_d;

    logic rx_xfer, f_syn, f_ack, f_rst, f_fin, in_order, close_idle, close_dest_listen;
    seq_t rcv_adv;

    assign rx_ready = !tx_valid && !rst;
    assign rx_xfer  = rx_valid && rx_ready;
    assign f_syn    = rx_flags[FLAG_SYN];
    assign f_ack    = rx_flags[FLAG_ACK];
    assign f_rst    = rx_flags[FLAG_RST];
    assign f_fin    = rx_flags[FLAG_FIN];
    assign in_order = (rx_seq == rcv_nxt_q);
    assign rcv_adv  = rcv_nxt_q + {16'd0, rx_len} + {31'd0, f_fin};
    // app_close yields to RX and to a pending TX segment.
    assign close_idle        = app_close && !rx_valid && !tx_valid;
    assign close_dest_listen = listen_en;

    logic unused_flags;
    assign unused_flags = ^{rx_flags[FLAG_URG], rx_flags[FLAG_PSH]};

`ifdef TCP_SERVER_TIMEOUT_EN
    logic [31:0] idle_q;
    logic        timeout_hit;
    assign timeout_hit = (state_q == ST_SYN_RCVD || state_q == ST_LAST_ACK) &&
                         !rx_xfer && (idle_q >= 32'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst || rx_xfer || (state_d != state_q)) begin
            idle_q <= '0;
        end else if (state_q == ST_SYN_RCVD || state_q == ST_LAST_ACK) begin
            idle_q <= idle_q + 32'd1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_d    = state_q;
        snd_nxt_d  = snd_nxt_q;
        rcv_nxt_d  = rcv_nxt_q;
        tx_load    = 1'b0;
        tx_flags_d = '0;
        tx_seq_d   = '0;
        tx_ack_d   = '0;
        case (state_q)
            ST_CLOSED: if (listen_en) state_d = ST_LISTEN;
            ST_LISTEN: begin
                if (!listen_en) begin
                    state_d = ST_CLOSED;
                end else if (rx_xfer && f_syn && !f_ack && !f_rst) begin
                    rcv_nxt_d  = rx_seq + 32'd1;
                    snd_nxt_d  = ISN + 32'd1;
                    tx_load    = 1'b1;
                    tx_flags_d = F_SYN | F_ACK;
                    tx_seq_d   = ISN;
                    tx_ack_d   = rx_seq + 32'd1;
                    state_d    = ST_SYN_RCVD;
                end
            end
            ST_SYN_RCVD: if (rx_xfer) begin
                if (f_rst) begin
                    state_d = ST_LISTEN;
                end else if (f_ack && rx_ack == snd_nxt_q) begin
                    state_d = ST_ESTABLISHED;
                end else if (f_ack) begin
                    tx_load    = 1'b1;
                    tx_flags_d = F_RST;
                    tx_seq_d   = rx_ack;
                end
            end
            ST_ESTABLISHED: if (rx_xfer) begin
                if (f_rst) begin
                    state_d = ST_LISTEN;
                end else if (in_order) begin
                    rcv_nxt_d = rcv_adv;
                    if (rx_len != 16'd0 || f_fin) begin
                        tx_load    = 1'b1;
                        tx_flags_d = F_ACK;
                        tx_seq_d   = snd_nxt_q;
                        tx_ack_d   = rcv_adv;
                    end
                    if (f_fin) state_d = ST_CLOSE_WAIT;
                end else if (rx_len != 16'd0) begin
                    // Duplicate ACK re-advertises the unchanged RCV.NXT.
                    tx_load    = 1'b1;
                    tx_flags_d = F_ACK;
                    tx_seq_d   = snd_nxt_q;
                    tx_ack_d   = rcv_nxt_q;
                end
            end
            ST_CLOSE_WAIT: begin
                if (rx_xfer) begin
                    if (f_rst) state_d = ST_LISTEN;
                end else if (close_idle) begin
                    tx_load    = 1'b1;
                    tx_flags_d = F_FIN | F_ACK;
                    tx_seq_d   = snd_nxt_q;
                    tx_ack_d   = rcv_nxt_q;
                    snd_nxt_d  = snd_nxt_q + 32'd1;
                    state_d    = ST_LAST_ACK;
                end
            end
            ST_LAST_ACK: if (rx_xfer && (f_rst || (f_ack && rx_ack == snd_nxt_q))) begin
                state_d = close_dest_listen ? ST_LISTEN : ST_CLOSED;
            end
            default: state_d = ST_CLOSED;
        endcase
`ifdef TCP_SERVER_TIMEOUT_EN
        if (timeout_hit) begin
            state_d = close_dest_listen ? ST_LISTEN : ST_CLOSED;
            tx_load = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLOSED;
            snd_nxt_q <= '0;
            rcv_nxt_q <= '0;
        end else begin
            state_q   <= state_d;
            snd_nxt_q <= snd_nxt_d;
            rcv_nxt_q <= rcv_nxt_d;
        end
    end

    tcp_tx_slot u_tx_slot (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tx_load),
        .flags_i    (tx_flags_d),
        .seq_i      (tx_seq_d),
        .ack_i      (tx_ack_d),
        .tx_ready_i (tx_ready),
        .tx_valid_o (tx_valid),
        .tx_flags_o (tx_flags),
        .tx_seq_o   (tx_seq),
        .tx_ack_o   (tx_ack)
    );

    assign state     = state_q;
    assign conn_open = (state_q == ST_ESTABLISHED);

endmodule

// File: tb/tb_tcp_server_core.sv
// tb/tb_tcp_server_core.sv - randomized self-checking bench for tcp_server_core
module tb_tcp_server_core;

    localparam logic [31:0] ISN = 32'h1000_0000;
    localparam logic [5:0] FIN = 6'h01, SYN = 6'h02, RST = 6'h04,
                           PSH = 6'h08, ACK = 6'h10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        listen_en = 1'b0;
    logic        app_close = 1'b0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [5:0]  rx_flags = '0;
    logic [31:0] rx_seq = '0;
    logic [31:0] rx_ack = '0;
    logic [15:0] rx_len = '0;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [5:0]  tx_flags;
    logic [31:0] tx_seq;
    logic [31:0] tx_ack;
    logic [2:0]  state;
    logic        conn_open;

    always #5 clk = ~clk;

    tcp_server_core #(.ISN(ISN), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .rst(rst), .listen_en(listen_en), .app_close(app_close),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_flags(rx_flags),
        .rx_seq(rx_seq), .rx_ack(rx_ack), .rx_len(rx_len),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_flags(tx_flags),
        .tx_seq(tx_seq), .tx_ack(tx_ack), .state(state), .conn_open(conn_open)
    );

    int total = 0;
    int bad = 0;

    // Reference connection: state number, sequence variables, expected TX.
    int          m_state;
    logic [31:0] m_snd, m_rcv;
    logic        e_tx;
    logic [5:0]  e_flags;
    logic [31:0] e_seq, e_ack;
    logic [5:0]  obs_flags;
    logic [31:0] obs_seq, obs_ack;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic emit(input logic [5:0] f, input logic [31:0] s, input logic [31:0] a);
        e_tx = 1'b1;
        e_flags = f;
        e_seq = s;
        e_ack = a;
    endtask

    task automatic model_reset();
        m_state = 0;
        m_snd = '0;
        m_rcv = '0;
        e_tx = 1'b0;
    endtask

    task automatic model_rx(input logic [5:0] f, input logic [31:0] s,
                            input logic [31:0] a, input logic [15:0] l);
        logic [31:0] fin_n;
        fin_n = (f & FIN) != 0 ? 32'd1 : 32'd0;
        e_tx = 1'b0;
        if (m_state == 0) begin
            if (listen_en) m_state = 1;
        end else if (m_state == 1) begin
            if (!listen_en) m_state = 0;
            else if ((f & SYN) != 0 && (f & ACK) == 0 && (f & RST) == 0) begin
                m_rcv = s + 1;
                m_snd = ISN + 1;
                emit(SYN | ACK, ISN, m_rcv);
                m_state = 2;
            end
        end else if (m_state == 2) begin
            if ((f & RST) != 0) m_state = 1;
            else if ((f & ACK) != 0) begin
                if (a == m_snd) m_state = 3;
                else emit(RST, a, 32'd0);
            end
        end else if (m_state == 3) begin
            if ((f & RST) != 0) m_state = 1;
            else if (s == m_rcv) begin
                m_rcv = m_rcv + {16'd0, l} + fin_n;
                if (l != 0 || fin_n != 0) emit(ACK, m_snd, m_rcv);
                if (fin_n != 0) m_state = 4;
            end else if (l != 0) begin
                emit(ACK, m_snd, m_rcv);
            end
        end else if (m_state == 4) begin
            if ((f & RST) != 0) m_state = 1;
        end else if (m_state == 5) begin
            if ((f & RST) != 0 || ((f & ACK) != 0 && a == m_snd))
                m_state = listen_en ? 1 : 0;
        end
    endtask

    task automatic check_resp(input int stall);
        chk("state", 32'(state), 32'(m_state));
        chk("conn_open", 32'(conn_open), (m_state == 3) ? 32'd1 : 32'd0);
        chk("tx_valid", 32'(tx_valid), 32'(e_tx));
        if (e_tx && tx_valid) begin
            chk("tx_flags", 32'(tx_flags), 32'(e_flags));
            chk("tx_seq", tx_seq, e_seq);
            chk("tx_ack", tx_ack, e_ack);
            obs_flags = tx_flags;
            obs_seq = tx_seq;
            obs_ack = tx_ack;
            for (int k = 0; k < stall; k++) begin
                tick();
                chk("stall_valid", 32'(tx_valid), 32'd1);
                chk("stall_rx_ready", 32'(rx_ready), 32'd0);
                chk("stall_flags", 32'(tx_flags), 32'(e_flags));
                chk("stall_seq", tx_seq, e_seq);
                chk("stall_ack", tx_ack, e_ack);
            end
        end
        if (tx_valid) begin
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
            chk("tx_drained", 32'(tx_valid), 32'd0);
            chk("rx_ready_after", 32'(rx_ready), 32'd1);
        end
    endtask

    task automatic send_seg(input logic [5:0] f, input logic [31:0] s, input logic [31:0] a,
                            input logic [15:0] l, input int stall);
        chk("rx_ready_pre", 32'(rx_ready), 32'd1);
        rx_flags = f;
        rx_seq = s;
        rx_ack = a;
        rx_len = l;
        rx_valid = 1'b1;
        model_rx(f, s, a, l);
        tick();
        rx_valid = 1'b0;
        check_resp(stall);
    endtask

    task automatic idle_cycle(input logic close);
        app_close = close;
        e_tx = 1'b0;
        if (close && m_state == 4) begin
            emit(FIN | ACK, m_snd, m_rcv);
            m_snd = m_snd + 1;
            m_state = 5;
        end else if (m_state == 0 && listen_en) m_state = 1;
        else if (m_state == 1 && !listen_en) m_state = 0;
        tick();
        app_close = 1'b0;
        check_resp($urandom_range(0, 2));
    endtask

    initial begin
        logic [5:0]  f;
        logic [31:0] s, a;
        logic [15:0] l;
        int          r;

        model_reset();
        tick();
        tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_flags", 32'(tx_flags), 32'd0);
        chk("rst_tx_seq", tx_seq, 32'd0);
        chk("rst_tx_ack", tx_ack, 32'd0);
        chk("rst_conn_open", 32'(conn_open), 32'd0);
        rst = 1'b0;
        idle_cycle(1'b0);
        chk("closed_rx_ready", 32'(rx_ready), 32'd1);
        listen_en = 1'b1;
        idle_cycle(1'b0);
        chk("listen_state", 32'(state), 32'd1);

        send_seg(SYN, 32'h0000_0100, 32'd0, 16'd0, 1);
        chk("synack_flags", 32'(obs_flags), 32'h12);
        chk("synack_seq", obs_seq, 32'h1000_0000);
        chk("synack_ack", obs_ack, 32'h0000_0101);
        send_seg(ACK, 32'h101, 32'h1000_0001, 16'd0, 0);
        chk("est_open", 32'(conn_open), 32'd1);
        send_seg(ACK | PSH, 32'h101, 32'h1000_0001, 16'd10, 0);
        chk("data_ack", obs_ack, 32'h10B);
        send_seg(ACK, 32'h200, 32'h1000_0001, 16'd4, 2);
        chk("dup_ack", obs_ack, 32'h10B);
        send_seg(ACK | FIN, 32'h10B, 32'h1000_0001, 16'd0, 0);
        chk("fin_ack", obs_ack, 32'h10C);
        chk("close_wait", 32'(state), 32'd4);
        idle_cycle(1'b1);
        chk("finack_flags", 32'(obs_flags), 32'h11);
        chk("finack_seq", obs_seq, 32'h1000_0001);
        send_seg(ACK, 32'h10C, 32'h1000_0002, 16'd0, 0);
        chk("back_listen", 32'(state), 32'd1);

        send_seg(SYN, 32'hFFFF_FFFF, 32'd0, 16'd0, 5);
        chk("wrap_ack", obs_ack, 32'h0000_0000);
        send_seg(ACK, 32'h0, 32'h0000_1234, 16'd0, 0);
        chk("rst_reply_flags", 32'(obs_flags), 32'h04);
        chk("rst_reply_seq", obs_seq, 32'h0000_1234);
        send_seg(RST, 32'h0, 32'h0, 16'd0, 0);
        listen_en = 1'b0;
        send_seg(SYN, 32'h55, 32'h0, 16'd0, 0);
        chk("listen_drop", 32'(state), 32'd0);
        listen_en = 1'b1;
        idle_cycle(1'b0);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 4) listen_en = ~listen_en;
            else if (!listen_en && r < 30) listen_en = 1'b1;
            if (m_state == 4 && r < 60) begin
                idle_cycle(1'b1);
            end else if (r >= 95) begin
                idle_cycle(1'b1);
            end else begin
                s = ($urandom_range(0, 9) < 7) ? m_rcv : $urandom;
                a = ($urandom_range(0, 9) < 7) ? m_snd : $urandom;
                l = ($urandom_range(0, 9) < 3) ? 16'd0 : 16'($urandom_range(1, 20));
                if ($urandom_range(0, 7) == 0) f = 6'($urandom);
                else if (m_state <= 1) begin
                    f = ($urandom_range(0, 4) == 0) ? (SYN | ACK) : SYN;
                    s = $urandom;
                end else begin
                    f = ACK;
                    if ($urandom_range(0, 9) == 0) f = f | FIN;
                    if ($urandom_range(0, 29) == 0) f = f | RST;
                end
                send_seg(f, s, a, l, $urandom_range(0, 3));
            end
        end

        listen_en = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        idle_cycle(1'b0);
        rx_flags = SYN;
        rx_seq = 32'h77;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk("midtx_valid", 32'(tx_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("midtx_rx_ready_rst", 32'(rx_ready), 32'd0);
        tick();
        chk("midtx_state", 32'(state), 32'd0);
        chk("midtx_tx_valid", 32'(tx_valid), 32'd0);
        chk("midtx_tx_seq", tx_seq, 32'd0);
        chk("midtx_tx_ack", tx_ack, 32'd0);
        chk("midtx_tx_flags", 32'(tx_flags), 32'd0);
        rst = 1'b0;
        #1;
        chk("midtx_rx_ready", 32'(rx_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tcp_server_core.md
# tcp_server_core

Passive-open TCP connection controller (server side, header-level only). It sits between a segment parser, which delivers decoded RX header fields, and a segment builder, which consumes TX header fields. It runs the RFC 793 server subset: listen, three-way handshake, data acknowledgement and passive close. It tracks SND.NXT/RCV.NXT; payload bytes never pass through it.

## Interface
- `ISN`, default 32'h1000_0000: initial send sequence number used in every SYN|ACK.
- `TIMEOUT_CYCLES`, default 1000: idle limit, used only when the timeout feature is compiled in.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `listen_en`  in  1  level; enables the passive open.
- `app_close`  in  1  level; application requests close.
- `rx_valid` / `rx_ready`  in / out  1  RX header handshake.
- `rx_flags`  in  6  {URG,ACK,PSH,RST,SYN,FIN}, bit5..bit0.
- `rx_seq`, `rx_ack`  in  32  received SEQ/ACK.
- `rx_len`  in  16  payload length of the received segment.
- `tx_valid` / `tx_ready`  out / in  1  TX header handshake.
- `tx_flags`  out  6  same encoding as `rx_flags`.
- `tx_seq`, `tx_ack`  out  32  SEQ/ACK to transmit.
- `state`  out  3  current state code.
- `conn_open`  out  1  high while the state is ESTABLISHED.

## Operation
- State codes: CLOSED=0, LISTEN=1, SYN_RCVD=2, ESTABLISHED=3, CLOSE_WAIT=4, LAST_ACK=5. Codes 6 and 7 recover to CLOSED on the next cycle.
- An RX transfer occurs when `rx_valid && rx_ready`.
- CLOSED: `listen_en`=1 -> LISTEN.
- LISTEN: `listen_en`=0 -> CLOSED. A segment with SYN, no ACK and no RST does all of the following:
  - RCV.NXT = `rx_seq`+1.
  - Emit SYN|ACK with seq=`ISN`, ack=RCV.NXT.
  - SND.NXT = `ISN`+1.
  - Go to SYN_RCVD.
- LISTEN: all other segments are silently dropped.
- SYN_RCVD:
  - RST -> LISTEN, no TX.
  - ACK with `rx_ack`==SND.NXT -> ESTABLISHED.
  - ACK with a wrong `rx_ack` -> emit RST with seq=`rx_ack`, ack=0; stay in SYN_RCVD.
  - Anything else is dropped.
- ESTABLISHED: RST -> LISTEN.
- ESTABLISHED, in-order segment (`rx_seq`==RCV.NXT):
  - RCV.NXT += `rx_len` + FIN.
  - If `rx_len`>0 or FIN, emit ACK with seq=SND.NXT, ack=the new RCV.NXT.
  - FIN -> CLOSE_WAIT.
- ESTABLISHED, out-of-order segment with `rx_len`>0: emit a duplicate ACK carrying the old RCV.NXT; no state change.
- ESTABLISHED, out-of-order segment with `rx_len`=0: dropped.
- CLOSE_WAIT: RST -> LISTEN. Otherwise `app_close` -> emit FIN|ACK with seq=SND.NXT, ack=RCV.NXT; SND.NXT += 1; go to LAST_ACK.
- LAST_ACK:
  - ACK with `rx_ack`==SND.NXT -> LISTEN if `listen_en`, else CLOSED.
  - RST -> same destination as the ACK case.
- `app_close` is ignored in every state except CLOSE_WAIT.
- All sequence arithmetic is modulo 2^32 (natural wrap). `rx_len` is zero-extended to 32 bits.

## Timing
- Reset values: state=CLOSED, `rx_ready`=0, `tx_valid`=0, `tx_flags`=0, `tx_seq`=0, `tx_ack`=0, `conn_open`=0, SND.NXT=0, RCV.NXT=0.
- `rx_ready` = !`tx_valid` && !`rst` (combinational from registers). At most one TX segment is pending.
- Response latency:
  - A TX segment is registered on the cycle after the RX transfer.
  - `tx_valid` rises that same cycle, along with the new state.
  - TX fields hold stable until `tx_valid && tx_ready`; `tx_valid` falls on the following edge.
- `app_close` is acted on only in a cycle with no RX transfer and `tx_valid`=0. RX always has priority.
- When `listen_en` falls in LISTEN while an RX transfer is in the same cycle, the segment is dropped and the state goes to CLOSED.
- `rst` asserted mid-handshake or mid-TX drops any pending TX and returns everything to the reset values on the next edge.

## Configuration
- `TCP_SERVER_TIMEOUT_EN` defined:
  - An idle counter clears on each RX transfer and on each state change.
  - It counts cycles while in SYN_RCVD or LAST_ACK.
  - When it reaches `TIMEOUT_CYCLES`, the state goes to LISTEN (or CLOSED if `listen_en`=0), with no TX.
- Undefined: no counter; those states wait indefinitely.

## Structure
- Shared package `tcp_pkg` holds:
  - state encoding constants;
  - flag bit indices (FIN=0, SYN=1, RST=2, PSH=3, ACK=4, URG=5);
  - the 32-bit sequence number type.
- One natural sub-module, `tcp_tx_slot`: a single-entry TX holding register with the valid/ready handshake.
- The FSM and sequence registers stay in the top module.

## Test plan
- Reset, then `listen_en`=1: state 0 -> 1; `rx_ready`=1; `tx_valid`=0.
- SYN with seq=0x0000_0100 in LISTEN -> SYN|ACK (flags 0x12), seq=0x1000_0000, ack=0x0000_0101; state 2.
- Then ACK with seq=0x101, ack=0x1000_0001 -> state 3, `conn_open`=1.
- Segment with seq=0x101, len=10 -> ACK with ack=0x10B. Segment with seq=0x200, len=4 -> duplicate ACK with ack=0x10B.
- FIN with seq=0x10B -> ACK with ack=0x10C, state 4. Then `app_close` -> FIN|ACK with seq=0x1000_0001, state 5. Then ACK with ack=0x1000_0002 -> state 1.
- SYN with seq=0xFFFF_FFFF -> ack=0x0000_0000 (wrap). Hold `tx_ready`=0 for 5 cycles -> TX fields stable and `rx_ready`=0 throughout.
